// File: rtl/dmem_mmio.sv
// Data memory with a small MMIO window: byte-writable RAM, a TX byte FIFO,
// a free-running cycle counter and a timer-compare interrupt.
module dmem_mmio #(
    parameter int DMEM_WORDS = 1024,
    parameter int TX_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_we,
    input  logic        data_re,
    output logic [31:0] data_rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        irq_timer
);

    localparam int AW = $clog2(DMEM_WORDS);
    localparam int PW = $clog2(TX_DEPTH);

    localparam logic [PW:0]   CNT_ONE     = (PW+1)'(32'd1);
    localparam logic [PW:0]   CNT_FULL    = (PW+1)'(TX_DEPTH);
    localparam logic [PW-1:0] PTR_ONE     = PW'(32'd1);
    localparam logic [3:0]    REGION_MMIO = 4'h1;
    localparam logic [3:0]    OFF_TXDATA  = 4'h0;
    localparam logic [3:0]    OFF_STATUS  = 4'h4;
    localparam logic [3:0]    OFF_CYCLE   = 4'h8;
    localparam logic [3:0]    OFF_TIMECMP = 4'hC;

    logic [31:0]   r_mem [DMEM_WORDS];
    logic [7:0]    r_buf [TX_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          r_ovf;
    logic [31:0]   r_cycle;
    logic [31:0]   r_timecmp;

    logic          w_mmio;
    logic [3:0]    w_off;
    logic [AW-1:0] w_idx;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic          w_irq;
    logic [31:0]   w_mmio_rdata;
    logic          w_unused;

    assign w_mmio    = (data_addr[31:28] == REGION_MMIO);
    assign w_off     = data_addr[3:0];
    assign w_idx     = data_addr[AW+1:2];
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_FULL);
    assign w_push    = w_mmio && (w_off == OFF_TXDATA) && data_we[0];
    assign w_pop     = !w_empty && tx_ready;
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_ovf_set = w_push && w_full && !w_pop;
    assign w_ovf_clr = w_mmio && (w_off == OFF_STATUS) && data_we[0] && data_wdata[3];
    assign w_irq     = (r_timecmp != 32'd0) && (r_cycle >= r_timecmp);
    assign w_unused  = &{1'b0, data_re, data_addr, data_wdata};

    assign data_rdata = w_mmio ? w_mmio_rdata : r_mem[w_idx];
    assign tx_valid   = !w_empty;
    assign tx_data    = r_buf[r_rptr];
    assign irq_timer  = w_irq;

    // MMIO register read mux; unmapped offsets read as zero.
    always_comb begin
        w_mmio_rdata = 32'd0;
        case (w_off)
            OFF_TXDATA:  w_mmio_rdata = 32'd0;
            OFF_STATUS:  w_mmio_rdata = {28'd0, r_ovf, w_irq, w_full, w_empty};
            OFF_CYCLE:   w_mmio_rdata = r_cycle;
            OFF_TIMECMP: w_mmio_rdata = r_timecmp;
            default:     w_mmio_rdata = 32'd0;
        endcase
    end

    // Byte-enabled RAM write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!w_mmio) begin
            for (int b = 0; b < 4; b++) begin
                if (data_we[b]) begin
                    r_mem[w_idx][8*b +: 8] <= data_wdata[8*b +: 8];
                end
            end
        end
    end

    // FIFO storage; only pointers and count need reset to empty it.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_buf[r_wptr] <= data_wdata[7:0];
        end
    end

    // FIFO control, sticky overflow, cycle counter and timer compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_cycle   <= 32'd0;
            r_timecmp <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            // Set wins over a simultaneous software clear.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_mmio && (w_off == OFF_TIMECMP)) begin
                for (int b = 0; b < 4; b++) begin
                    if (data_we[b]) begin
                        r_timecmp[8*b +: 8] <= data_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: a per-cycle comparison against a byte/queue
// model plus hand-computed literal checks for each scenario.
module tb_dmem_mmio;

    localparam int DW  = 1024;
    localparam int TXD = 8;

    localparam logic [31:0] A_TX  = 32'h1000_0000;
    localparam logic [31:0] A_ST  = 32'h1000_0004;
    localparam logic [31:0] A_CYC = 32'h1000_0008;
    localparam logic [31:0] A_TC  = 32'h1000_000C;

    logic        clk;
    logic        rst;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_we;
    logic        data_re;
    logic [31:0] data_rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        irq_timer;

    int total = 0;
    int bad   = 0;

    // Model state: RAM as known bytes, FIFO as a queue, registers as numbers.
    logic [7:0]  m_bytes [int];
    logic [7:0]  m_q [$];
    logic        m_ovf;
    logic [31:0] m_cycle;
    logic [31:0] m_tcmp;

    dmem_mmio #(.DMEM_WORDS(DW), .TX_DEPTH(TXD)) dut (
        .clk(clk), .rst(rst), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_we(data_we), .data_re(data_re), .data_rdata(data_rdata),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .irq_timer(irq_timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] we, input logic rdy);
        @(posedge clk);
        #1;
        data_addr  = a;
        data_wdata = wd;
        data_we    = we;
        data_re    = (we == 4'd0);
        tx_ready   = rdy;
    endtask

    // Per-cycle comparison against the model, then advance the model to the next edge.
    always @(negedge clk) begin : cmp
        logic [31:0] exp_rd;
        logic        exp_irq;
        logic        known;
        logic        pop;
        logic        full_before;
        int          base;
        if (rst) begin
            chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
            chk("rst_irq", {31'd0, irq_timer}, 32'd0);
            m_q.delete();
            m_ovf   = 1'b0;
            m_cycle = 32'd0;
            m_tcmp  = 32'd0;
        end else begin
            exp_irq = (m_tcmp != 32'd0) && (m_cycle >= m_tcmp);
            chk("irq", {31'd0, irq_timer}, {31'd0, exp_irq});
            chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_q.size() != 0});
            if (m_q.size() != 0) chk("tx_data", {24'd0, tx_data}, {24'd0, m_q[0]});
            known = 1'b1;
            exp_rd = 32'd0;
            base = int'((data_addr / 4) % DW) * 4;
            if (data_addr[31:28] == 4'h1) begin
                if (data_addr[3:0] == 4'h4)
                    exp_rd = {28'd0, m_ovf, exp_irq, m_q.size() == TXD, m_q.size() == 0};
                else if (data_addr[3:0] == 4'h8) exp_rd = m_cycle;
                else if (data_addr[3:0] == 4'hC) exp_rd = m_tcmp;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (m_bytes.exists(base + b)) exp_rd[8*b +: 8] = m_bytes[base + b];
                    else known = 1'b0;
                end
            end
            if (known) chk("rdata", data_rdata, exp_rd);

            full_before = (m_q.size() == TXD);
            pop = (m_q.size() != 0) && tx_ready;
            if (data_addr[31:28] != 4'h1) begin
                for (int b = 0; b < 4; b++)
                    if (data_we[b]) m_bytes[base + b] = data_wdata[8*b +: 8];
            end else begin
                if (pop) void'(m_q.pop_front());
                if (data_addr[3:0] == 4'h0 && data_we[0]) begin
                    if (!full_before || pop) m_q.push_back(data_wdata[7:0]);
                    else m_ovf = 1'b1;
                end else if (data_addr[3:0] == 4'h4 && data_we[0] && data_wdata[3]) begin
                    m_ovf = 1'b0;
                end
                if (data_addr[3:0] == 4'hC)
                    for (int b = 0; b < 4; b++)
                        if (data_we[b]) m_tcmp[8*b +: 8] = data_wdata[8*b +: 8];
            end
            if (data_addr[31:28] != 4'h1 && pop) void'(m_q.pop_front());
            m_cycle = m_cycle + 32'd1;
        end
    end

    initial begin
        logic [7:0] exp_order [8];
        rst = 1'b1;
        data_addr = A_CYC; data_wdata = 32'd0; data_we = 4'd0; data_re = 1'b0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Timer: CYCLE is 1 in the first cycle driven after reset; write TIMECMP=20 at cycle 5.
        repeat (4) drive(A_CYC, 32'd0, 4'd0, 1'b0);
        drive(A_TC, 32'd20, 4'hF, 1'b0);
        for (int k = 6; k <= 22; k++) begin
            drive(A_CYC, 32'd0, 4'd0, 1'b0);
            #2;
            chk("cycle_read", data_rdata, 32'(k));
            chk("irq_at_cycle", {31'd0, irq_timer}, {31'd0, k >= 20});
        end
        drive(A_TC, 32'd0, 4'hF, 1'b0);
        #2 chk("irq_before_clear_edge", {31'd0, irq_timer}, 32'd1);
        drive(A_CYC, 32'd0, 4'd0, 1'b0);
        #2 chk("irq_cleared", {31'd0, irq_timer}, 32'd0);
        chk("cycle_24", data_rdata, 32'd24);

        // RAM byte merge: lane 1 replaced with 0xAA, lane 0 keeps 0xEF.
        drive(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0);
        #2 chk("ram_old_on_write", data_rdata === 32'hDEAD_BEEF ? 32'd1 : 32'd0, 32'd0);
        drive(32'h0000_0101, 32'h0000_AA00, 4'b0010, 1'b0);
        drive(32'h0000_0100, 32'd0, 4'd0, 1'b0);
        #2 chk("ram_byte_merge", data_rdata, 32'hDEAD_AAEF);
        drive(32'h0000_0100 + 4 * DW, 32'd0, 4'd0, 1'b0);
        #2 chk("ram_alias", data_rdata, 32'hDEAD_AAEF);
        drive(32'h0000_0103, 32'd0, 4'd0, 1'b0);
        #2 chk("ram_low_bits_ignored", data_rdata, 32'hDEAD_AAEF);

        // Single push, then a one-cycle pop.
        drive(A_TX, 32'h0000_0041, 4'b0001, 1'b0);
        #2 chk("txdata_reads_zero", data_rdata, 32'd0);
        chk("no_bypass", {31'd0, tx_valid}, 32'd0);
        drive(A_ST, 32'd0, 4'd0, 1'b0);
        #2 chk("status_one_byte", data_rdata, 32'h0);
        chk("head_41", {24'd0, tx_data}, 32'h41);
        drive(A_ST, 32'd0, 4'd0, 1'b1);
        drive(A_ST, 32'd0, 4'd0, 1'b0);
        #2 chk("status_empty", data_rdata, 32'h1);

        // Overflow: TX_DEPTH+1 pushes with no consumer.
        for (int i = 0; i <= TXD; i++) drive(A_TX, 32'(8'h10 + i), 4'b0001, 1'b0);
        drive(A_ST, 32'd0, 4'd0, 1'b0);
        #2 chk("status_full_ovf", data_rdata, 32'hA);
        for (int i = 0; i < TXD; i++) begin
            drive(A_ST, 32'd0, 4'd0, 1'b1);
            #2 chk("drain_order", {24'd0, tx_data}, 32'(8'h10 + i));
        end
        drive(A_ST, 32'd0, 4'd0, 1'b0);
        #2 chk("status_empty_ovf", data_rdata, 32'h9);
        drive(A_ST, 32'h0000_0008, 4'b0001, 1'b0);
        drive(A_ST, 32'd0, 4'd0, 1'b0);
        #2 chk("ovf_cleared", data_rdata, 32'h1);

        // Push into a full FIFO while the head pops.
        for (int i = 0; i < TXD; i++) drive(A_TX, 32'(8'h20 + i), 4'b0001, 1'b0);
        drive(A_TX, 32'h0000_0055, 4'b0001, 1'b1);
        drive(A_ST, 32'd0, 4'd0, 1'b0);
        #2 chk("full_push_pop_status", data_rdata, 32'h2);
        for (int i = 0; i < 7; i++) exp_order[i] = 8'h21 + 8'(i);
        exp_order[7] = 8'h55;
        for (int i = 0; i < TXD; i++) begin
            drive(A_ST, 32'd0, 4'd0, 1'b1);
            #2 chk("drain_after_swap", {24'd0, tx_data}, {24'd0, exp_order[i]});
        end
        drive(A_ST, 32'd0, 4'd0, 1'b0);
        #2 chk("empty_after_swap", data_rdata, 32'h1);

        // Asynchronous reset with three bytes queued.
        for (int i = 0; i < 3; i++) drive(A_TX, 32'(8'h61 + i), 4'b0001, 1'b0);
        drive(A_CYC, 32'd0, 4'd0, 1'b0);
        #2 chk("queued_before_rst", {31'd0, tx_valid}, 32'd1);
        rst = 1'b1;
        #1 chk("async_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("async_rst_cycle", data_rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(32'h0000_0100, 32'd0, 4'd0, 1'b0);
        #2 chk("ram_retained", data_rdata, 32'hDEAD_AAEF);
        drive(A_CYC, 32'd0, 4'd0, 1'b0);
        #2 chk("cycle_after_rst", data_rdata, 32'd2);
        repeat (2) drive(A_ST, 32'd0, 4'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
